axis_rr_arbiter: RTL
====================

# axis_rr_arbiter

Packet-level round-robin arbiter that shares the single write port of the AXI-Stream ring buffer among N AXI-Stream sources. It sits directly upstream of the buffer's slave interface. It grants one source at a time and holds the grant until that source's `tlast` beat completes, so packets are never interleaved inside the buffer. It also exposes the current grant and, optionally, per-source packet counters.

## Interface
- `N`, 4: number of requesting sources, 2..16.
- `width`, 64: tdata width in bits.
- `CW`, 32: width of each packet counter (used only with `ARB_STATS_EN`).

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  N*width  source data; source i occupies bits [i*width +: width].
- `s_axis_tvalid`  in  N  per-source valid.
- `s_axis_tlast`  in  N  per-source end-of-packet.
- `s_axis_tready`  out  N  per-source ready.
- `m_axis_tdata`  out  width  data to the ring buffer.
- `m_axis_tvalid`  out  1  valid to the ring buffer.
- `m_axis_tlast`  out  1  end-of-packet to the ring buffer.
- `m_axis_tready`  in  1  ready from the ring buffer (deasserted when the buffer is full).
- `grant_id`  out  clog2(N)  index of the granted source; meaningful only when `busy`=1.
- `busy`  out  1  1 while a grant is held (state LOCK).
- `stats_clr`  in  1  synchronous clear of all packet counters.
- `pkt_count`  out  N*CW  completed-packet count per source; source i occupies bits [i*CW +: CW].

## Operation
- FSM has two states: IDLE and LOCK. A registered pointer `last` holds the most recent winner.
- IDLE:
  - `m_axis_tvalid`=0 and all `s_axis_tready`=0.
  - If any `s_axis_tvalid` is 1, pick the first requesting index scanning from `last+1`, wrapping modulo N.
  - Register the winner into `grant_id`, set `busy`=1, and go to LOCK.
- LOCK, with g = `grant_id`:
  - `m_axis_tdata`/`tvalid`/`tlast` = source g's signals, combinational.
  - `s_axis_tready[g]` = `m_axis_tready`; all other readies are 0.
  - A beat transfers when `m_axis_tvalid & m_axis_tready`.
  - On a transfer with `tlast`=1: set `last`←g, go to IDLE, and set `busy`←0.
- The grant is never revoked mid-packet:
  - Source g deasserting `tvalid` leaves the arbiter in LOCK.
  - `m_axis_tready` held low (buffer full) leaves the arbiter in LOCK indefinitely.
- Requests arriving or withdrawn during LOCK do not affect the current grant. They are considered only at the next IDLE.
- Fairness: after source i completes a packet, every other requesting source is served before i again.

## Timing
- Reset values, applied immediately on `rst` and held until release:
  - state=IDLE, `last`=N-1 (source 0 has first priority), `grant_id`=0, `busy`=0.
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, all `s_axis_tready`=0, all counters=0.
- Arbitration latency:
  - A request seen in IDLE at edge k gives LOCK from edge k; the first beat can transfer in cycle k+1.
- Packet-to-packet gap is exactly one IDLE cycle after each `tlast` transfer.
- The data path is combinational through the mux in LOCK. There is no added pipeline latency, and beats are passed through one per cycle with no bubbles.
- A single-beat packet (`tlast` on the first beat) occupies 1 LOCK cycle, then 1 IDLE cycle.
- Reset asserted during LOCK aborts the grant:
  - Any partial packet is abandoned; the buffer-side framing is the system's responsibility.
  - The counter for the abandoned packet is not incremented.

## Configuration
- `ARB_STATS_EN` defined:
  - `pkt_count[i]` increments by 1 in the cycle a `tlast` beat from source i transfers, wrapping at 2^CW.
  - `stats_clr`=1 zeroes all counters. Clear wins over a simultaneous increment.
- `ARB_STATS_EN` undefined:
  - Counter logic is not synthesized; `pkt_count` is tied to 0.
  - `stats_clr` is ignored.
  - Ports remain so instantiations are unchanged.

## Test plan
- Reset release, with sources 0 and 2 both valid, 3-beat packets and `m_axis_tready`=1 -> source 0 is granted first and transfers 3 beats; 1 IDLE cycle follows; then source 2 is granted; `grant_id` reads 0 then 2.
- All 4 sources continuously valid, 2-beat packets -> grant order 0,1,2,3,0,1; exactly 1 idle cycle between packets.
- Source 1 granted on a 4-beat packet; source 0 asserts valid at beat 2 -> source 1 completes all 4 beats uninterrupted; source 0 is granted next.
- `m_axis_tready` held 0 for 10 cycles mid-packet -> `busy` stays 1, `grant_id` is unchanged, no beats are lost or duplicated, and the data order is preserved after ready returns.
- Async `rst` pulse mid-packet -> all outputs go to their reset values without waiting for a clock edge; after release, source 0 has priority.
- With `ARB_STATS_EN`: 5 packets from source 3 -> `pkt_count[3]`=5 and the others 0; pulse `stats_clr` together with a `tlast` beat -> all counters 0.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter sharing one AXI-Stream sink among N sources.
// Define ARB_STATS_EN to build the per-source completed-packet counters.
module axis_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned width = 64,
  parameter int unsigned CW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*width-1:0]      s_axis_tdata,
  input  logic [N-1:0]            s_axis_tvalid,
  input  logic [N-1:0]            s_axis_tlast,
  output logic [N-1:0]            s_axis_tready,
  output logic [width-1:0]        m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [$clog2(N)-1:0]    grant_id,
  output logic                    busy,
  input  logic                    stats_clr,
  output logic [N*CW-1:0]         pkt_count
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_grant;
  logic          r_busy;

  logic [IW-1:0] w_pick;
  logic          w_any_req;
  logic          w_xfer;
  logic          w_xfer_last;

  assign w_any_req = |s_axis_tvalid;

  // Round-robin pick: scan downward so the smallest offset from r_last+1 wins last.
  always_comb begin : pick
    logic [IW-1:0] v_idx;
    v_idx  = '0;
    w_pick = r_last;
    for (int unsigned k = N; k >= 1; k--) begin
      v_idx = IW'((32'(r_last) + k) % N);
      if (s_axis_tvalid[v_idx]) begin
        w_pick = v_idx;
      end
    end
  end

  // Combinational path from the granted source to the sink; everything idles low otherwise.
  always_comb begin : mux
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (r_state == ST_LOCK) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (r_grant == IW'(i)) begin
          m_axis_tdata     = s_axis_tdata[i*width +: width];
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tlast     = s_axis_tlast[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign w_xfer      = m_axis_tvalid & m_axis_tready;
  assign w_xfer_last = w_xfer & m_axis_tlast;

  // Grant is taken in IDLE and only released by the granted source's tlast transfer.
  always_ff @(posedge clk or posedge rst) begin : fsm
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= IW'(N - 1);
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_xfer_last) begin
            r_last  <= r_grant;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_id = r_grant;
  assign busy     = r_busy;

`ifdef ARB_STATS_EN
  logic [CW-1:0] r_cnt [N];

  // Completed-packet counters; a clear in the same cycle as a tlast beat wins.
  always_ff @(posedge clk or posedge rst) begin : stats
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (stats_clr) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (w_xfer_last && (r_grant == IW'(i))) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin : stats_out
    pkt_count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pkt_count[i*CW +: CW] = r_cnt[i];
    end
  end
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr;
  assign pkt_count          = '0;
`endif

endmodule
